// File: rtl/uart_tx_frame.sv
// UART transmitter: serialises one latched word per accepted request as
// start bit, LSB-first data, optional even/odd parity bit and one stop bit.
module uart_tx_frame #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      DATA_VALID,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
    output logic                      TX_OUT,
    output logic                      BUSY
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                    state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] cyc_q, cyc_d;
    logic [PRESCALE_WIDTH-1:0] last_q, last_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic [DATA_WIDTH-1:0]     shift_q, shift_d;
    logic                      par_en_q, par_en_d;
    logic                      par_q, par_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;
    logic                      bit_end;

    // last_q holds B-1, so PRESCALE=0 and PRESCALE=1 both give one cycle per bit
    assign bit_end = (cyc_q == last_q);

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        last_d   = last_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_en_d = par_en_q;
        par_d    = par_q;

        case (state_q)
            S_IDLE: begin
                if (DATA_VALID) begin
                    state_d  = S_START;
                    shift_d  = P_DATA;
                    par_en_d = PAR_EN;
                    par_d    = PAR_TYP ? ~^P_DATA : ^P_DATA;
                    last_d   = (PRESCALE == '0) ? '0 : PRESCALE - PRESCALE_WIDTH'(1);
                    cyc_d    = '0;
                    bit_d    = '0;
                end
            end
            S_START: begin
                cyc_d = bit_end ? '0 : cyc_q + PRESCALE_WIDTH'(1);
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                cyc_d = bit_end ? '0 : cyc_q + PRESCALE_WIDTH'(1);
                if (bit_end) begin
                    if (bit_q == LAST_BIT) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                cyc_d = bit_end ? '0 : cyc_q + PRESCALE_WIDTH'(1);
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                cyc_d = bit_end ? '0 : cyc_q + PRESCALE_WIDTH'(1);
                if (bit_end) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered line
    // changes on the same edge as the state it belongs to.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = 1'b1;
        case (state_d)
            S_IDLE:   busy_d = 1'b0;
            S_START:  tx_d   = 1'b0;
            S_DATA:   tx_d   = shift_d[0];
            S_PARITY: tx_d   = par_d;
            S_STOP:   tx_d   = 1'b1;
            default:  busy_d = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            cyc_q    <= '0;
            last_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            last_q   <= last_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_en_q <= par_en_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
        end
    end

    assign TX_OUT = tx_q;
    assign BUSY   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboarded bench for uart_tx_frame: the driver queues the expected serial
// frame for each accepted word, a negedge monitor checks the line cycle by cycle.
module tb_uart_tx_frame;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          DATA_VALID;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic [PW-1:0] PRESCALE;
    logic          TX_OUT;
    logic          BUSY;

    uart_tx_frame #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .PRESCALE(PRESCALE),
        .TX_OUT(TX_OUT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [DW+2:0] bits;
        int            nb;
        int            b;
    } frame_t;

    frame_t exp_q[$];
    frame_t cur;
    int     checks = 0;
    int     errors = 0;
    int     ncyc = 0;
    int     k = 0;
    int     end_cyc = 0;
    int     last_gap = 0;
    int     busy_len = 0;
    int     last_busy_len = 0;
    bit     in_frame = 1'b0;
    bit     mon_en = 1'b0;
    logic   rst_at_edge = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, ncyc, act, exp);
        end
    endtask

    // Reference frame: the line value for each bit slot, plus bit time.
    function automatic frame_t make_frame(input logic [DW-1:0] d, input logic pe,
                                          input logic pt, input int ps);
        frame_t f;
        int ones = 0;
        f.bits = '1;
        f.bits[0] = 1'b0;
        for (int i = 0; i < DW; i++) begin
            f.bits[1+i] = d[i];
            ones += int'(d[i]);
        end
        if (pe) f.bits[DW+1] = pt ? ((ones % 2) == 0) : ((ones % 2) == 1);
        f.nb = DW + 2 + int'(pe);
        f.b  = (ps == 0) ? 1 : ps;
        return f;
    endfunction

    always @(posedge CLK) rst_at_edge <= RST;

    always @(negedge CLK) begin
        ncyc++;
        if (mon_en) begin
            if (rst_at_edge) begin
                chk("reset_tx", TX_OUT, 1);
                chk("reset_busy", BUSY, 0);
                in_frame = 1'b0;
            end else begin
                if (!in_frame && BUSY === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", BUSY, 0);
                    end else begin
                        cur = exp_q.pop_front();
                        in_frame = 1'b1;
                        k = 0;
                        busy_len = 0;
                        last_gap = ncyc - end_cyc;
                    end
                end
                if (in_frame) begin
                    if (k < cur.nb * cur.b) begin
                        chk("busy_in_frame", BUSY, 1);
                        chk("line_bit", TX_OUT, cur.bits[k / cur.b]);
                        busy_len++;
                        k++;
                    end else begin
                        chk("busy_fall", BUSY, 0);
                        chk("stop_to_idle_line", TX_OUT, 1);
                        in_frame = 1'b0;
                        end_cyc = ncyc;
                        last_busy_len = busy_len;
                    end
                end else if (BUSY !== 1'b1) begin
                    chk("idle_line", {BUSY, TX_OUT}, 2'b01);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (BUSY !== 1'b0) begin
            @(posedge CLK);
            #1;
            n++;
            if (n > 2000) begin
                chk("idle_timeout", BUSY, 0);
                return;
            end
        end
    endtask

    // Called with the DUT idle; the word is accepted at the next edge, after
    // which the inputs are scrambled to prove they are no longer used.
    task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt,
                        input logic [PW-1:0] ps);
        exp_q.push_back(make_frame(d, pe, pt, int'(ps)));
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; PRESCALE = ps;
        DATA_VALID = 1'b1;
        cycles(1);
        DATA_VALID = 1'b0;
        P_DATA = DW'($urandom);
        PAR_EN = 1'($urandom);
        PAR_TYP = 1'($urandom);
        PRESCALE = PW'($urandom);
    endtask

    initial begin
        RST = 1'b1; DATA_VALID = 1'b1; P_DATA = 8'h3C;
        PAR_EN = 1'b0; PAR_TYP = 1'b0; PRESCALE = 6'd2;
        cycles(1);
        mon_en = 1'b1;
        cycles(1);
        exp_q.push_back(make_frame(8'h3C, 1'b0, 1'b0, 2));
        RST = 1'b0;
        cycles(1);
        DATA_VALID = 1'b0;
        wait_idle();
        cycles(2);

        send(8'hA6, 1'b1, 1'b0, 6'd4);
        wait_idle(); cycles(2);
        chk("len_even_p4", last_busy_len, 44);

        send(8'hAA, 1'b1, 1'b1, 6'd32);
        wait_idle(); cycles(2);
        chk("len_odd_p32", last_busy_len, 352);

        send(8'h05, 1'b0, 1'b0, 6'd1);
        wait_idle(); cycles(2);
        chk("len_nopar_p1", last_busy_len, 10);

        // Back-to-back with DATA_VALID held; data changes mid-frame.
        exp_q.push_back(make_frame(8'hAA, 1'b1, 1'b0, 4));
        exp_q.push_back(make_frame(8'h05, 1'b1, 1'b0, 4));
        P_DATA = 8'hAA; PAR_EN = 1'b1; PAR_TYP = 1'b0; PRESCALE = 6'd4;
        DATA_VALID = 1'b1;
        cycles(1);
        P_DATA = 8'h05;
        wait_idle();
        cycles(1);
        DATA_VALID = 1'b0;
        P_DATA = 8'hFF;
        wait_idle(); cycles(2);
        chk("b2b_gap", last_gap, 1);
        chk("b2b_len", last_busy_len, 44);

        // Abort during data bit 3 (cycles 17..20 of the frame).
        send(8'hA6, 1'b1, 1'b0, 6'd4);
        cycles(17);
        RST = 1'b1;
        cycles(1);
        RST = 1'b0;
        void'(exp_q.pop_front());
        cycles(2);
        send(8'h05, 1'b1, 1'b0, 6'd4);
        wait_idle(); cycles(2);
        chk("after_abort_len", last_busy_len, 44);

        for (int i = 0; i < 25; i++) begin
            logic [DW-1:0] d;
            logic pe, pt;
            logic [PW-1:0] ps;
            d  = DW'($urandom);
            pe = 1'($urandom);
            pt = 1'($urandom);
            ps = PW'($urandom_range(0, 5));
            send(d, pe, pt, ps);
            wait_idle();
            cycles($urandom_range(0, 2));
        end
        cycles(3);
        chk("queue_drained", exp_q.size(), 0);
        chk("no_open_frame", in_frame, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
